// File: rtl/rv32i_single_cycle_core.sv
// ---------------------------------------------------------------------------
// rv32i_single_cycle_core
//
// Single-cycle RV32I integer core. Every rising edge of clk retires one
// instruction. The instruction ROM and data RAM sit outside the core.
// Both are read combinationally. The RAM writes on the rising edge while
// memory_we is high.
//
// Ports:
//   clk            system clock; all state changes on the rising edge
//   rst_n          asynchronous active-low reset
//   instruction    instruction word at address pc (combinational ROM data)
//   pc             current program counter (byte address)
//   memory_address rs1 + immediate (I-type for loads/JALR, S-type for stores)
//   memory_out     RAM read data (combinational)
//   memory_write   store data (rs2 value)
//   memory_we      high only while a SW executes; never high in reset
//
// Build option:
//   CPU_REGFILE_RESET_EN  when defined, reset also clears x1..x31.
//                         Otherwise only pc is reset.
// ---------------------------------------------------------------------------
module rv32i_single_cycle_core #(
  parameter int                 XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] memory_address,
  input  logic [XLEN-1:0] memory_out,
  output logic [XLEN-1:0] memory_write,
  output logic            memory_we
);

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Instruction fields and immediates
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = instruction[6:0];
  assign rd     = instruction[11:7];
  assign funct3 = instruction[14:12];
  assign rs1    = instruction[19:15];
  assign rs2    = instruction[24:20];

  assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u = {instruction[31:12], 12'b0};
  assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // Register file. Entry 0 is never written; reads of x0 are forced to zero.
  logic [XLEN-1:0] regs [0:31];
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            rd_wen;
  logic [XLEN-1:0] rd_data;

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

`ifdef CPU_REGFILE_RESET_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (rd_wen && rd != 5'd0) begin
      regs[rd] <= rd_data;
    end
  end
`else
  // No reset on the array. rst_n still blocks writes while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && rd_wen && rd != 5'd0) regs[rd] <= rd_data;
  end
`endif

  // ALU: shared by OP and OP-IMM. funct7[5] (instruction[30]) selects SUB only
  // for register ADD. It selects SRA/SRAI for both shift-right forms.
  logic [XLEN-1:0] alu_b, alu_y, sra_y;
  logic [4:0]      shamt;
  logic            alu_alt;

  assign alu_b   = (opcode == OP_REG) ? rs2_val : imm_i;
  assign shamt   = alu_b[4:0];
  assign alu_alt = instruction[30] &
                   (((opcode == OP_REG) && (funct3 == 3'b000)) || (funct3 == 3'b101));
  assign sra_y   = $signed(rs1_val) >>> shamt;

  always_comb begin
    case (funct3)
      3'b000:  alu_y = alu_alt ? (rs1_val - alu_b) : (rs1_val + alu_b);
      3'b001:  alu_y = rs1_val << shamt;
      3'b010:  alu_y = {31'b0, $signed(rs1_val) < $signed(alu_b)};
      3'b011:  alu_y = {31'b0, rs1_val < alu_b};
      3'b100:  alu_y = rs1_val ^ alu_b;
      3'b101:  alu_y = alu_alt ? sra_y : (rs1_val >> shamt);
      3'b110:  alu_y = rs1_val | alu_b;
      default: alu_y = rs1_val & alu_b;
    endcase
  end

  // Branch condition
  logic take;
  always_comb begin
    case (funct3)
      3'b000:  take = (rs1_val == rs2_val);
      3'b001:  take = (rs1_val != rs2_val);
      3'b100:  take = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  take = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  take = (rs1_val <  rs2_val);
      3'b111:  take = (rs1_val >= rs2_val);
      default: take = 1'b0;
    endcase
  end

  // One adder computes the load/store address. JALR reuses it: the I-imm
  // is selected for every opcode except STORE.
  assign memory_address = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign memory_write   = rs2_val;

  logic [XLEN-1:0] pc_plus4, next_pc;
  logic            store_en;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    next_pc  = pc_plus4;
    rd_wen   = 1'b0;
    rd_data  = alu_y;
    store_en = 1'b0;
    case (opcode)
      OP_REG, OP_IMM: rd_wen = 1'b1;
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_wen  = 1'b1;
          rd_data = memory_out;
        end
      end
      OP_STORE:  store_en = (funct3 == 3'b010);
      OP_BRANCH: if (take) next_pc = pc + imm_b;
      OP_JAL: begin
        rd_wen  = 1'b1;
        rd_data = pc_plus4;
        next_pc = pc + imm_j;
      end
      OP_JALR: begin
        rd_wen  = 1'b1;
        rd_data = pc_plus4;
        next_pc = {memory_address[XLEN-1:1], 1'b0};
      end
      OP_LUI: begin
        rd_wen  = 1'b1;
        rd_data = imm_u;
      end
      OP_AUIPC: begin
        rd_wen  = 1'b1;
        rd_data = pc + imm_u;
      end
      default: ;
    endcase
  end

  // Gated by rst_n so the RAM can never be written while reset is held
  assign memory_we = store_en & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc <= RESET_PC;
    else        pc <= next_pc;
  end

endmodule

// File: tb/tb_rv32i_single_cycle_core.sv
// ---------------------------------------------------------------------------
// tb_rv32i_single_cycle_core
//
// Instruction-level reference model run in lockstep with the core.
// Phases:
//   - a directed program (arithmetic, SW/LW, branches, AUIPC/JALR, x0,
//     undefined opcode)
//   - an asynchronous reset in the middle of the program
//   - a randomized program whose register state is dumped through SW
// Honours CPU_REGFILE_RESET_EN the same way the core does.
// ---------------------------------------------------------------------------
module tb_rv32i_single_cycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction, pc, memory_address, memory_out, memory_write;
  logic        memory_we;

  always #5 clk = ~clk;

  rv32i_single_cycle_core #(.XLEN(32), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instruction    (instruction),
    .pc             (pc),
    .memory_address (memory_address),
    .memory_out     (memory_out),
    .memory_write   (memory_write),
    .memory_we      (memory_we)
  );

  // ROM / RAM seen by the core
  logic [31:0] rom [0:511];
  logic [31:0] ram [0:63];
  logic        ram_clr;
  logic        ovr_en;
  logic [31:0] ovr_instr;

  assign instruction = ovr_en ? ovr_instr : rom[pc[10:2]];
  assign memory_out  = ram[memory_address[7:2]];

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 64; i++) ram[i] <= '0;
    end else if (memory_we) begin
      ram[memory_address[7:2]] <= memory_write;
    end
  end

  // Reference model state
  logic [31:0] m_regs [0:31];
  logic [31:0] m_mem  [0:63];
  logic [31:0] m_pc;

  // Model predictions for the current instruction
  logic        e_we, e_wr;
  logic [31:0] e_addr, e_data, e_next, e_val;
  logic [4:0]  e_rd;

  logic        obs_we;
  logic [31:0] obs_wdata;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Instruction encoders
  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] s_type(input logic [11:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] u_type(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction
  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Arithmetic by the ISA's definitions
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
      input logic [31:0] x, input logic [31:0] y);
    int unsigned sh;
    sh = y % 32;
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << sh;
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: begin
        if (alt) return 32'($signed(x) >>> sh);
        return x >> sh;
      end
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  task automatic model_eval(input logic [31:0] ins);
    logic [31:0] a, b, ii, si, bi, ji, ui, ad;
    logic [2:0]  f3;
    logic        tk;
    f3 = ins[14:12];
    a  = m_regs[ins[19:15]];
    b  = m_regs[ins[24:20]];
    ii = 32'($signed(ins) >>> 20);
    si = {ii[31:5], ins[11:7]};
    bi = 32'(($signed(ins) >>> 31) << 12) | {20'b0, ins[7], ins[30:25], ins[11:8], 1'b0};
    ji = 32'(($signed(ins) >>> 31) << 20) | {12'b0, ins[19:12], ins[20], ins[30:21], 1'b0};
    ui = {ins[31:12], 12'b0};
    e_we = 1'b0; e_addr = '0; e_data = '0; e_next = m_pc + 32'd4;
    e_wr = 1'b0; e_rd = ins[11:7]; e_val = '0;
    case (ins[6:0])
      7'h33: begin e_wr = 1'b1; e_val = alu_ref(f3, ins[30], a, b); end
      7'h13: begin e_wr = 1'b1; e_val = alu_ref(f3, (f3 == 3'd5) && ins[30], a, ii); end
      7'h03: if (f3 == 3'd2) begin
        ad = a + ii;
        e_wr = 1'b1; e_val = m_mem[ad[7:2]];
      end
      7'h23: if (f3 == 3'd2) begin e_we = 1'b1; e_addr = a + si; e_data = b; end
      7'h63: begin
        case (f3)
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 1'b0;
        endcase
        if (tk) e_next = m_pc + bi;
      end
      7'h6f: begin e_wr = 1'b1; e_val = m_pc + 32'd4; e_next = m_pc + ji; end
      7'h67: begin e_wr = 1'b1; e_val = m_pc + 32'd4; e_next = (a + ii) & ~32'd1; end
      7'h37: begin e_wr = 1'b1; e_val = ui; end
      7'h17: begin e_wr = 1'b1; e_val = m_pc + ui; end
      default: ;
    endcase
  endtask

  // One retired instruction: compare before the edge, commit model after it
  task automatic step();
    @(negedge clk);
    model_eval(rom[m_pc[10:2]]);
    $display("pc=%h ins=%h we=%b addr=%h wdata=%h", pc, instruction, memory_we,
             memory_address, memory_write);
    check_eq("pc", pc, m_pc);
    check_eq("mem_we", 32'(memory_we), 32'(e_we));
    obs_we    = memory_we;
    obs_wdata = memory_write;
    if (e_we) begin
      check_eq("st_addr", memory_address, e_addr);
      check_eq("st_data", memory_write, e_data);
    end
    @(posedge clk);
    if (e_we) m_mem[e_addr[7:2]] = e_data;
    if (e_wr && e_rd != 5'd0) m_regs[e_rd] = e_val;
    m_pc = e_next;
  endtask

  // Reset asserted between edges while a store is presented
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0; ovr_en = 1'b1; ovr_instr = s_type(12'd0, 5'd1, 5'd0, 3'd2);
    #1;
    check_eq("rst_pc", pc, 32'h0);
    check_eq("rst_we", 32'(memory_we), 32'd0);
    @(posedge clk);
    #1;
    check_eq("rst_pc_hold", pc, 32'h0);
    rst_n = 1'b1; ovr_en = 1'b0;
    m_pc = 32'h0;
`ifdef CPU_REGFILE_RESET_EN
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
`endif
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 512; i++) rom[i] = NOP;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rd, rs1, rs2;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [11:0] imm;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom); f3 = 3'($urandom);
    case ($urandom_range(0, 11))
      0, 1, 2: begin
        f7 = ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        return r_type(f7, rs2, rs1, f3, rd);
      end
      3, 4, 5: begin
        if (f3 == 3'd1) imm = {7'h00, 5'($urandom)};
        else if (f3 == 3'd5) imm = {($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom)};
        else imm = 12'($urandom);
        return i_type(imm, rs1, f3, rd, 7'h13);
      end
      6: return u_type(20'($urandom), rd, ($urandom_range(0, 1) == 1) ? 7'h37 : 7'h17);
      7: return i_type({4'b0, 6'($urandom), 2'b0}, 5'd0, 3'd2, rd, 7'h03);
      8: return s_type({4'b0, 6'($urandom), 2'b0}, rs2, 5'd0, 3'd2);
      9: begin
        if (f3 == 3'd2 || f3 == 3'd3) f3 = 3'd1;
        return b_type(13'(4 * $urandom_range(1, 4)), rs2, rs1, f3);
      end
      10: return j_type(21'(4 * $urandom_range(1, 4)), rd);
      default: begin
        case ($urandom_range(0, 2))
          0: return {25'($urandom), 7'h7f};
          1: return i_type(12'($urandom), rs1, 3'd0, rd, 7'h03);
          default: return s_type(12'($urandom), rs2, rs1, 3'd0);
        endcase
      end
    endcase
  endfunction

  initial begin
    int idx;
    int cyc;
    logic [31:0] end_addr;

    rst_n = 1'b1; ovr_en = 1'b1; ovr_instr = NOP; ram_clr = 1'b1;
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    for (int i = 0; i < 64; i++) m_mem[i] = '0;
    @(posedge clk);
    #1 ram_clr = 1'b0;

    // ---- Directed program ----
    clear_rom();
    rom[0]  = i_type(12'd30, 5'd0, 3'd0, 5'd2, 7'h13);    // ADDI x2,x0,30
    rom[1]  = i_type(12'd20, 5'd0, 3'd0, 5'd3, 7'h13);    // ADDI x3,x0,20
    rom[2]  = r_type(7'h20, 5'd3, 5'd2, 3'd0, 5'd1);      // SUB x1,x2,x3
    rom[3]  = s_type(12'd0, 5'd1, 5'd0, 3'd2);            // SW x1,0(x0)
    rom[4]  = s_type(12'd4, 5'd1, 5'd0, 3'd2);            // SW x1,4(x0)
    rom[5]  = i_type(12'd4, 5'd0, 3'd2, 5'd12, 7'h03);    // LW x12,4(x0)
    rom[6]  = b_type(13'd8, 5'd3, 5'd2, 3'd0);            // BEQ x2,x3,+8
    rom[7]  = b_type(13'd8, 5'd3, 5'd2, 3'd1);            // BNE x2,x3,+8
    rom[8]  = i_type(12'd99, 5'd0, 3'd0, 5'd1, 7'h13);    // skipped
    rom[9]  = i_type(12'd5, 5'd0, 3'd0, 5'd0, 7'h13);     // ADDI x0,x0,5
    rom[10] = u_type(20'd0, 5'd5, 7'h17);                 // AUIPC x5,0
    rom[11] = i_type(12'd0, 5'd0, 3'd0, 5'd10, 7'h67);    // JALR x10,x0,0
    do_reset();

    repeat (3) step();
    #1 check_eq("pc_after3", pc, 32'd12);
    step(); check_eq("sw0_we", 32'(obs_we), 32'd1);
    step(); check_eq("sw1_we", 32'(obs_we), 32'd1);
    step(); check_eq("lw_we", 32'(obs_we), 32'd0);
    #1;
    check_eq("ram_w0", ram[0], 32'd10);
    check_eq("ram_w1", ram[1], 32'd10);
    step(); #1 check_eq("beq_not_taken", pc, 32'd28);
    step(); #1 check_eq("bne_taken", pc, 32'd36);
    repeat (3) step();
    #1 check_eq("jalr_target", pc, 32'd0);

    // Dump results of the directed program through stores
    clear_rom();
    rom[0] = s_type(12'd8,  5'd12, 5'd0, 3'd2);
    rom[1] = s_type(12'd12, 5'd0,  5'd0, 3'd2);
    rom[2] = s_type(12'd16, 5'd5,  5'd0, 3'd2);
    rom[3] = s_type(12'd20, 5'd10, 5'd0, 3'd2);
    rom[4] = s_type(12'd24, 5'd1,  5'd0, 3'd2);
    rom[5] = 32'h0000_007F;
    rom[6] = i_type(12'd1, 5'd0, 3'd0, 5'd7, 7'h13);
    step(); check_eq("x12", obs_wdata, 32'd10);
    step(); check_eq("x0", obs_wdata, 32'd0);
    step(); check_eq("x5_auipc", obs_wdata, 32'd40);
    step(); check_eq("x10_link", obs_wdata, 32'd48);
    step(); check_eq("x1_skip", obs_wdata, 32'd10);
    step(); #1 check_eq("undef_pc", pc, 32'd24);
    check_eq("undef_we", 32'(obs_we), 32'd0);
    step();

    // ---- Mid-program asynchronous reset ----
    clear_rom();
`ifdef CPU_REGFILE_RESET_EN
    for (int r = 1; r < 32; r++) rom[r-1] = s_type(12'(4 * r), 5'(r), 5'd0, 3'd2);
`endif
    do_reset();
`ifdef CPU_REGFILE_RESET_EN
    for (int r = 1; r < 32; r++) begin
      step();
      check_eq("reg_cleared", obs_wdata, 32'd0);
    end
`endif

    // ---- Randomized program ----
    clear_rom();
    idx = 0;
    for (int r = 1; r < 32; r++) begin
      rom[idx] = i_type(12'($urandom), 5'd0, 3'd0, 5'(r), 7'h13);
      idx++;
    end
    for (int n = 0; n < 160; n++) begin
      rom[idx] = rand_instr();
      idx++;
    end
    idx += 5;
    for (int r = 1; r < 32; r++) begin
      rom[idx] = s_type(12'(4 * r), 5'(r), 5'd0, 3'd2);
      idx++;
    end
    end_addr = 32'(idx * 4);
    do_reset();
    cyc = 0;
    while (m_pc != end_addr && cyc < 2000) begin
      step();
      cyc++;
    end
    #1 check_eq("reach_end", pc, end_addr);
    for (int i = 0; i < 64; i++) check_eq("ram_final", ram[i], m_mem[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
